mult32x32: RTL and testbench

MULT32X32 -- requirements
Module: mult32x32

---
 rtl/mult32x32_pkg.sv | 36 +++
 rtl/mult32x32_fsm.sv | 38 +++
 rtl/mult32x32.sv | 116 +++++++++++
 tb/tb_mult32x32.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mult32x32_pkg.sv
// Shared types and widths for the 32x32 sequential multiplier.
// Compile-time option used by the slice: MULT32X32_INPUT_REG_EN.
package mult32x32_pkg;

  localparam int STATE_W   = 4;
  localparam int OP_W      = 32;
  localparam int A_SLICE_W = 8;
  localparam int B_SLICE_W = 16;
  localparam int PART_W    = A_SLICE_W + B_SLICE_W;
  localparam int PROD_W    = 64;
  localparam int SHIFT_W   = 6;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 4'd0,
    ST_A0B0 = 4'd1,
    ST_A1B0 = 4'd2,
    ST_A2B0 = 4'd3,
    ST_A3B0 = 4'd4,
    ST_A0B1 = 4'd5,
    ST_A1B1 = 4'd6,
    ST_A2B1 = 4'd7,
    ST_A3B1 = 4'd8
  } state_t;

  // Weight of partial product Ai*Bj is 2^(8*i + 16*j).
  function automatic logic [PROD_W-1:0] place_partial(
    input logic [PART_W-1:0] part,
    input logic [1:0]        a_idx,
    input logic              b_idx
  );
    logic [SHIFT_W-1:0] shamt;
    shamt = {1'b0, b_idx, 4'b0000} + {1'b0, a_idx, 3'b000};
    return {{(PROD_W-PART_W){1'b0}}, part} << shamt;
  endfunction

endpackage

// File: rtl/mult32x32_fsm.sv
// Sequencer for the multiplier: walks the eight byte-by-halfword partial products.
module mult32x32_fsm
  import mult32x32_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   start,
  output state_t current,
  output state_t next
);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      current <= ST_IDLE;
    end else begin
      current <= next;
    end
  end

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    next = ST_IDLE;
    case (current)
      ST_IDLE: next = start ? ST_A0B0 : ST_IDLE;
      ST_A0B0: next = ST_A1B0;
      ST_A1B0: next = ST_A2B0;
      ST_A2B0: next = ST_A3B0;
      ST_A3B0: next = ST_A0B1;
      ST_A0B1: next = ST_A1B1;
      ST_A1B1: next = ST_A2B1;
      ST_A2B1: next = ST_A3B1;
      ST_A3B1: next = ST_IDLE;
      default: next = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/mult32x32.sv
// 32x32 unsigned multiplier using one 8x16 partial-product multiplier over eight cycles.
// Define MULT32X32_INPUT_REG_EN to capture a/b at start so they may change while busy.
module mult32x32
  import mult32x32_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [OP_W-1:0]     a,
  input  logic [OP_W-1:0]     b,
  output logic                busy,
  output logic [PROD_W-1:0]   product
);

  state_t                 current_s;
  state_t                 next_s;
  logic                   accept_s;
  logic [OP_W-1:0]        op_a_s;
  logic [OP_W-1:0]        op_b_s;
  logic [1:0]             a_idx_s;
  logic                   b_idx_s;
  logic [A_SLICE_W-1:0]   a_byte_s;
  logic [B_SLICE_W-1:0]   b_half_s;
  logic [PART_W-1:0]      partial_s;
  logic [PROD_W-1:0]      placed_s;
  logic [PROD_W-1:0]      product_r;

  mult32x32_fsm u_fsm (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .current (current_s),
    .next    (next_s)
  );

  assign accept_s = (current_s == ST_IDLE) && (next_s == ST_A0B0);

`ifdef MULT32X32_INPUT_REG_EN
  logic [OP_W-1:0] a_r;
  logic [OP_W-1:0] b_r;

  // Operand capture on the accepting edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r <= {OP_W{1'b0}};
      b_r <= {OP_W{1'b0}};
    end else if (accept_s) begin
      a_r <= a;
      b_r <= b;
    end else begin
      a_r <= a_r;
      b_r <= b_r;
    end
  end

  assign op_a_s = a_r;
  assign op_b_s = b_r;
`else
  assign op_a_s = a;
  assign op_b_s = b;
`endif

  // Slice indices for the current compute state; IDLE selects slice 0 but is never accumulated.
  always_comb begin
    a_idx_s = 2'd0;
    b_idx_s = 1'b0;
    case (current_s)
      ST_A0B0: begin a_idx_s = 2'd0; b_idx_s = 1'b0; end
      ST_A1B0: begin a_idx_s = 2'd1; b_idx_s = 1'b0; end
      ST_A2B0: begin a_idx_s = 2'd2; b_idx_s = 1'b0; end
      ST_A3B0: begin a_idx_s = 2'd3; b_idx_s = 1'b0; end
      ST_A0B1: begin a_idx_s = 2'd0; b_idx_s = 1'b1; end
      ST_A1B1: begin a_idx_s = 2'd1; b_idx_s = 1'b1; end
      ST_A2B1: begin a_idx_s = 2'd2; b_idx_s = 1'b1; end
      ST_A3B1: begin a_idx_s = 2'd3; b_idx_s = 1'b1; end
      default: begin a_idx_s = 2'd0; b_idx_s = 1'b0; end
    endcase
  end

  // Operand slice muxes.
  always_comb begin
    a_byte_s = op_a_s[7:0];
    case (a_idx_s)
      2'd0:    a_byte_s = op_a_s[7:0];
      2'd1:    a_byte_s = op_a_s[15:8];
      2'd2:    a_byte_s = op_a_s[23:16];
      2'd3:    a_byte_s = op_a_s[31:24];
      default: a_byte_s = op_a_s[7:0];
    endcase
    if (b_idx_s) begin
      b_half_s = op_b_s[31:16];
    end else begin
      b_half_s = op_b_s[15:0];
    end
  end

  assign partial_s = {{B_SLICE_W{1'b0}}, a_byte_s} * {{A_SLICE_W{1'b0}}, b_half_s};
  assign placed_s  = place_partial(partial_s, a_idx_s, b_idx_s);

  // Accumulator: cleared on accept, adds one weighted partial per compute state, else holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      product_r <= {PROD_W{1'b0}};
    end else if (accept_s) begin
      product_r <= {PROD_W{1'b0}};
    end else if (current_s != ST_IDLE) begin
      product_r <= product_r + placed_s;
    end else begin
      product_r <= product_r;
    end
  end

  assign busy    = (current_s != ST_IDLE);
  assign product = product_r;

endmodule

// File: tb/tb_mult32x32.sv
// Self-checking bench for mult32x32; expected products come from plain 64-bit arithmetic.
module tb_mult32x32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic [63:0] product;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mult32x32 dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .product (product)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation; poke_at re-asserts start on that busy cycle, scramble changes a/b while busy.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input int poke_at,
                        input bit scramble, input string tag);
    logic [63:0] exp;
    int n;
    exp = 64'(x) * 64'(y);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      start = (n == poke_at);
      if (scramble) begin
`ifdef MULT32X32_INPUT_REG_EN
        a = $urandom; b = $urandom;
`endif
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " busy_cycles"}, 64'(n), 64'd8);
    chk({tag, " product"}, product, exp);
    @(negedge clk);
    chk({tag, " product_hold"}, product, exp);
    chk({tag, " idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] exp;
    int n;

    // Reset held for 4 cycles.
    repeat (4) @(negedge clk);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset product", product, 64'd0);
    reset = 1'b1;

    run_op(32'd322979956, 32'd300086550, 0, 1'b0, "ref");
    chk("ref constant", product, 64'd96921940715191800);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, "max");
    chk("max constant", product, 64'hFFFF_FFFE_0000_0001);
    run_op(32'd0, 32'h1234_5678, 0, 1'b0, "zero_a");
    run_op(32'd1, 32'hFFFF_FFFF, 0, 1'b0, "one_a");
    chk("one_a constant", product, 64'h0000_0000_FFFF_FFFF);
    run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 3, 1'b0, "start_while_busy");
    run_op(32'h8000_0001, 32'h0001_8000, 8, 1'b0, "start_last_busy");

    // Asynchronous reset on the 4th busy cycle.
    @(negedge clk);
    a = 32'hCAFE_F00D; b = 32'h7654_3210; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort pre busy", {63'd0, busy}, 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort busy", {63'd0, busy}, 64'd0);
    chk("abort product", product, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(32'h1357_9BDF, 32'h2468_ACE0, 0, 1'b0, "after_abort");

    // Start held high: back-to-back operations with a single idle cycle between.
    @(negedge clk);
    a = 32'h0F0F_1234; b = 32'hA5A5_5A5A; start = 1'b1;
    exp = 64'(32'h0F0F_1234) * 64'(32'hA5A5_5A5A);
    @(negedge clk);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("held busy_cycles", 64'(n), 64'd8);
    chk("held product", product, exp);
    @(negedge clk);
    chk("held restart", {63'd0, busy}, 64'd1);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("held second product", product, exp);

    // Randomised operands; with capture enabled a/b are also scrambled while busy.
    for (int i = 0; i < 8; i++) begin
      run_op($urandom, $urandom, 0, 1'b1, "rand");
    end
    run_op(32'hFFFF_0000, 32'h0000_FFFF, 0, 1'b1, "scramble");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
